// File: rtl/seq_div4.sv
// seq_div4: sequential restoring divider, one quotient bit per clock.
//   iClk, iRst_n (async active-low)            clock / reset
//   iStart, iDividend, iDivisor                request + operands, taken in IDLE or DONE
//   oBusy, oDone                               CALC in progress / one-cycle result pulse
//   oQuot, oRem                                results, held until the next DONE
//   oDivZero                                   only with `define ARITH_DIVZERO_CHK_EN
module seq_div4 #(
  parameter int WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuot,
  output logic [WIDTH-1:0] oRem
`ifdef ARITH_DIVZERO_CHK_EN
  ,
  output logic             oDivZero
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] rem, sh, rem_n;
  logic [WIDTH-1:0] dvd, dvs, dvd_n;
  logic ge, accept, dz, dz_r, last;
  assign accept = iStart && state != CALC;
  assign last = state == CALC && cnt == CW'(1);
`ifdef ARITH_DIVZERO_CHK_EN
  // A zero divisor spends a single CALC cycle so oDone lands one clock after accept.
  assign dz = iDivisor == '0;
`else
  assign dz = 1'b0;
`endif
  // Dividend register doubles as the quotient shift register.
  always_comb begin
    sh = (rem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
    ge = sh >= {1'b0, dvs};
    rem_n = ge ? sh - {1'b0, dvs} : sh;
    dvd_n = {dvd[WIDTH-2:0], ge};
  end
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = accept ? CALC : last ? DONE : state == CALC ? CALC : IDLE;
  end
  always_comb begin
    oBusy = state == CALC;
    oDone = state == DONE;
  end
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      dz_r <= 1'b0;
      oQuot <= '0;
      oRem <= '0;
    end else if (accept) begin
      cnt <= dz ? CW'(1) : CW'(WIDTH);
      rem <= '0;
      dvd <= iDividend;
      dvs <= iDivisor;
      dz_r <= dz;
    end else if (state == CALC) begin
      cnt <= cnt - 1'b1;
      rem <= rem_n;
      dvd <= dvd_n;
      if (last) begin
        oQuot <= dz_r ? '1 : dvd_n;
        oRem <= dz_r ? dvd : rem_n[WIDTH-1:0];
      end
    end
`ifdef ARITH_DIVZERO_CHK_EN
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) oDivZero <= 1'b0;
    else if (accept) oDivZero <= 1'b0;
    else if (last) oDivZero <= dz_r;
`endif
endmodule

// File: tb/tb_seq_div4.sv
// tb_seq_div4: scoreboard bench for seq_div4 at WIDTH=4.
module tb_seq_div4;
  logic iClk, iRst_n, iStart, oBusy, oDone;
  logic [3:0] iDividend, iDivisor, oQuot, oRem;
  logic oDivZero;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [3:0] q; logic [3:0] r; logic dz; int lat;} exp_t;
  exp_t sbq[$];

  seq_div4 dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iDividend(iDividend),
    .iDivisor(iDivisor), .oBusy(oBusy), .oDone(oDone), .oQuot(oQuot), .oRem(oRem)
`ifdef ARITH_DIVZERO_CHK_EN
    , .oDivZero(oDivZero)
`endif
  );
`ifndef ARITH_DIVZERO_CHK_EN
  assign oDivZero = 1'b0;
`endif

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic start(input int a, input int b);
    exp_t e;
    e.q = b == 0 ? 4'hF : 4'(a / b);
    e.r = b == 0 ? 4'(a) : 4'(a % b);
`ifdef ARITH_DIVZERO_CHK_EN
    e.dz = b == 0;
    e.lat = b == 0 ? 1 : 4;
`else
    e.dz = 1'b0;
    e.lat = 4;
`endif
    sbq.push_back(e);
    iDividend = 4'(a);
    iDivisor = 4'(b);
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge iClk); #1;
      n++;
    end while (!oDone && n < 20);
  endtask

  task automatic test_reset;
    iRst_n = 1'b0; iStart = 1'b0; iDividend = '0; iDivisor = '0;
    repeat (2) @(posedge iClk);
    #1;
    n_cmp++;
    if ({oBusy, oDone, oQuot, oRem, oDivZero} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 0", {oBusy, oDone, oQuot, oRem, oDivZero});
    end
    iRst_n = 1'b1;
    @(posedge iClk); #1;
  endtask

  task automatic test_basic;
    exp_t e;
    start(13, 4);
    for (int i = 1; i <= 3; i++) begin
      @(posedge iClk); #1;
      n_cmp++;
      if (oBusy !== 1'b1 || oDone !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_busy cycle %0d got busy=%b done=%b want busy=1 done=0", i, oBusy, oDone);
      end
    end
    @(posedge iClk); #1;
    e = sbq.pop_front();
    n_cmp++;
    if (oDone !== 1'b1 || oBusy !== 1'b0 || oQuot !== e.q || oRem !== e.r) begin
      n_bad++;
      $display("FAIL basic_13_4 got done=%b busy=%b q=%0d r=%0d want done=1 busy=0 q=%0d r=%0d",
               oDone, oBusy, oQuot, oRem, e.q, e.r);
    end
    @(posedge iClk); #1;
    n_cmp++;
    if (oDone !== 1'b0 || oQuot !== e.q || oRem !== e.r) begin
      n_bad++;
      $display("FAIL basic_pulse_hold got done=%b q=%0d r=%0d want done=0 q=%0d r=%0d",
               oDone, oQuot, oRem, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int n;
    start(15, 1);
    wait_done(n);
    e = sbq.pop_front();
    n_cmp++;
    if (n !== e.lat || oQuot !== e.q || oRem !== e.r || oDivZero !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_15_1 got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d dz=0",
               n, oQuot, oRem, oDivZero, e.lat, e.q, e.r);
    end
    start(5, 7);
    n_cmp++;
    if (oBusy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_no_bubble got busy=%b want 1", oBusy);
    end
    wait_done(n);
    e = sbq.pop_front();
    n_cmp++;
    if (n !== e.lat || oQuot !== e.q || oRem !== e.r) begin
      n_bad++;
      $display("FAIL b2b_5_7 got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
               n, oQuot, oRem, e.lat, e.q, e.r);
    end
  endtask

  task automatic test_divzero;
    exp_t e;
    int n;
    start(9, 0);
    wait_done(n);
    e = sbq.pop_front();
    n_cmp++;
    if (n !== e.lat || oQuot !== e.q || oRem !== e.r || oDivZero !== e.dz) begin
      n_bad++;
      $display("FAIL divzero_9_0 got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d dz=%b",
               n, oQuot, oRem, oDivZero, e.lat, e.q, e.r, e.dz);
    end
    start(6, 3);
    n_cmp++;
    if (oDivZero !== 1'b0) begin
      n_bad++;
      $display("FAIL divzero_clear got dz=%b want 0", oDivZero);
    end
    wait_done(n);
    e = sbq.pop_front();
    n_cmp++;
    if (n !== e.lat || oQuot !== e.q || oRem !== e.r || oDivZero !== 1'b0) begin
      n_bad++;
      $display("FAIL divzero_after_6_3 got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d dz=0",
               n, oQuot, oRem, oDivZero, e.lat, e.q, e.r);
    end
  endtask

  task automatic test_ignore;
    exp_t e;
    int n;
    start(12, 5);
    @(posedge iClk); #1;
    iDividend = 4'd3; iDivisor = 4'd3; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    wait_done(n);
    e = sbq.pop_front();
    n_cmp++;
    if (n !== 2 || oQuot !== e.q || oRem !== e.r) begin
      n_bad++;
      $display("FAIL ignore_12_5 got remaining=%0d q=%0d r=%0d want remaining=2 q=%0d r=%0d",
               n, oQuot, oRem, e.q, e.r);
    end
    @(posedge iClk); #1;
    n_cmp++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_idle got busy=%b done=%b want 0 0", oBusy, oDone);
    end
  endtask

  task automatic test_abort;
    exp_t e;
    int n;
    logic seen;
    start(14, 3);
    @(posedge iClk); #1;
    iRst_n = 1'b0;
    #1;
    sbq.delete();
    n_cmp++;
    if ({oBusy, oDone, oQuot, oRem, oDivZero} !== 11'b0) begin
      n_bad++;
      $display("FAIL abort_async got %b want 0", {oBusy, oDone, oQuot, oRem, oDivZero});
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) iRst_n = 1'b1;
      @(posedge iClk); #1;
      seen |= oDone | oBusy;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_done got activity=%b want 0", seen);
    end
    start(14, 3);
    wait_done(n);
    e = sbq.pop_front();
    n_cmp++;
    if (n !== e.lat || oQuot !== e.q || oRem !== e.r) begin
      n_bad++;
      $display("FAIL abort_retry_14_3 got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
               n, oQuot, oRem, e.lat, e.q, e.r);
    end
  endtask

  task automatic test_sweep;
    exp_t e;
    int n;
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++) begin
        start(a, b);
        wait_done(n);
        e = sbq.pop_front();
        n_cmp++;
        if (n !== e.lat || oQuot !== e.q || oRem !== e.r ||
            int'(oQuot) * b + int'(oRem) != a || int'(oRem) >= b) begin
          n_bad++;
          $display("FAIL sweep_%0d_%0d got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
                   a, b, n, oQuot, oRem, e.lat, e.q, e.r);
        end
      end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_divzero;
    test_ignore;
    test_abort;
    test_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
